alu_acc: RTL and testbench

- Parametrised accumulator ALU: WIDTH-bit successor of the 4-bit registered ALU.
- Holds its own accumulator (ACC), carry and zero flags.
- Accepts one instruction per valid/ready handshake and returns each result through a valid/ready output stage.
- Adds carry-chained arithmetic, compare/test and multi-cycle iterative shifts; sits between the instruction sequencer and the register/output path.

---
 rtl/alu_acc.sv | 199 +++++++++++++++++++
 tb/tb_alu_acc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc.sv
// alu_acc -- parametrised accumulator ALU with valid/ready instruction and
// result handshakes. Holds ACC plus registered carry (C) and zero (Z) flags.
// Single-cycle ops complete on the accept edge; SHL/SHR/ROL by N>=1 shift one
// bit per clock and complete N edges after the accept.
//
// Optional feature macro: ALU_ACC_SHIFT_EN
//   defined   : iterative SHL/SHR/ROL with SHIFT state and bit counter
//   undefined : opcodes 0010/0011/1111 behave as NOP, BUSY tied low
//
// Ports:
//   CLK        clock, all state on rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   instruction present          IN_READY  block can accept
//   INST       4-bit opcode                 IN_DATA   operand / shift count
//   OUT_VALID  result present               OUT_READY consumer takes result
//   OUT_DATA   accumulator value            C, Z      carry/borrow, zero flags
//   BUSY       iterative shift in progress
module alu_acc #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [3:0]       INST,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic             C,
   output logic             Z,
   output logic             BUSY
);

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LD  = 4'b0001;
   localparam logic [3:0] OP_SHL = 4'b0010;
   localparam logic [3:0] OP_SHR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SBB = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_NEG = 4'b1001;
   localparam logic [3:0] OP_OR  = 4'b1010;
   localparam logic [3:0] OP_CMP = 4'b1011;
   localparam logic [3:0] OP_AND = 4'b1100;
   localparam logic [3:0] OP_TST = 4'b1101;
   localparam logic [3:0] OP_XOR = 4'b1110;
   localparam logic [3:0] OP_ROL = 4'b1111;

   logic [WIDTH-1:0] acc;
   logic             c_q;
   logic             z_q;
   logic             ov_q;
   logic             accept;

   logic             start_shift;   // accept that enters the SHIFT state
   logic             shifting;      // one shift step happens this edge
   logic             shift_done;    // last shift step happens this edge
   logic [WIDTH:0]   step;          // {bit moved, shifted value}

   assign accept    = IN_VALID && IN_READY;
   assign OUT_VALID = ov_q;
   assign OUT_DATA  = acc;
   assign C         = c_q;
   assign Z         = z_q;

`ifdef ALU_ACC_SHIFT_EN
   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q;
   state_t           state_n;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       sh_op_q;
   logic             is_shift_op;

   // One-bit step for the latched shift opcode; MSB of the return is the bit
   // leaving (SHL/SHR) or wrapping into the LSB (ROL).
   function automatic logic [WIDTH:0] shift_step(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a);
      case (op)
         OP_SHR:  return {a[0], 1'b0, a[WIDTH-1:1]};
         OP_ROL:  return {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
         default: return {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      endcase
   endfunction

   assign is_shift_op = (INST == OP_SHL) || (INST == OP_SHR) || (INST == OP_ROL);
   assign start_shift = accept && is_shift_op && (IN_DATA[CNT_W-1:0] != '0);
   assign shifting    = (state_q == S_SHIFT);
   assign shift_done  = shifting && (cnt_q == CNT_W'(1));
   assign step        = shift_step(sh_op_q, acc);
   assign IN_READY    = (state_q == S_IDLE) && (!ov_q || OUT_READY);
   assign BUSY        = shifting;

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (start_shift) state_n = S_SHIFT;
         S_SHIFT: if (cnt_q == CNT_W'(1)) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_op_q <= OP_NOP;
      end else begin
         state_q <= state_n;
         if (start_shift) begin
            cnt_q   <= IN_DATA[CNT_W-1:0];
            sh_op_q <= INST;
         end else if (shifting) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end
`else
   assign start_shift = 1'b0;
   assign shifting    = 1'b0;
   assign shift_done  = 1'b0;
   assign step        = '0;
   assign IN_READY    = !ov_q || OUT_READY;
   assign BUSY        = 1'b0;
`endif

   // Single-cycle result path: next ACC, carry and the value Z is taken from
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic             add_cin;
   logic             sub_bin;
   logic [WIDTH-1:0] alu_acc_n;
   logic             alu_c_n;
   logic [WIDTH-1:0] alu_res;

   assign add_cin = (INST == OP_ADC) && c_q;
   assign sub_bin = (INST == OP_SBB) && c_q;
   assign sum_w   = {1'b0, acc} + {1'b0, IN_DATA} + {{WIDTH{1'b0}}, add_cin};
   // Top bit of the extended difference is the borrow.
   assign diff_w  = {1'b0, acc} - {1'b0, IN_DATA} - {{WIDTH{1'b0}}, sub_bin};

   always_comb begin
      alu_acc_n = acc;
      alu_c_n   = c_q;
      case (INST)
         OP_LD:           begin alu_acc_n = IN_DATA;          alu_c_n = 1'b0;        end
         OP_ADD, OP_ADC:  begin alu_acc_n = sum_w[WIDTH-1:0];  alu_c_n = sum_w[WIDTH]; end
         OP_SUB, OP_SBB:  begin alu_acc_n = diff_w[WIDTH-1:0]; alu_c_n = diff_w[WIDTH]; end
         OP_NOT:          begin alu_acc_n = ~acc;              alu_c_n = 1'b0;        end
         OP_NEG:          begin alu_acc_n = (~acc) + {{(WIDTH-1){1'b0}}, 1'b1}; alu_c_n = |acc; end
         OP_OR:           begin alu_acc_n = acc | IN_DATA;     alu_c_n = 1'b0;        end
         OP_AND:          begin alu_acc_n = acc & IN_DATA;     alu_c_n = 1'b0;        end
         OP_XOR:          begin alu_acc_n = acc ^ IN_DATA;     alu_c_n = 1'b0;        end
         OP_CMP:          alu_c_n = diff_w[WIDTH];
         OP_TST:          alu_c_n = 1'b0;
`ifdef ALU_ACC_SHIFT_EN
         // Only a zero count reaches here as a completed op: A kept, C cleared.
         OP_SHL, OP_SHR, OP_ROL: alu_c_n = 1'b0;
`endif
         default: ;
      endcase
   end

   always_comb begin
      alu_res = alu_acc_n;
      if (INST == OP_CMP) alu_res = diff_w[WIDTH-1:0];
      else if (INST == OP_TST) alu_res = acc & IN_DATA;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc  <= '0;
         c_q  <= 1'b0;
         z_q  <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         if (OUT_READY) ov_q <= 1'b0;
         if (accept && !start_shift) begin
            acc  <= alu_acc_n;
            c_q  <= alu_c_n;
            z_q  <= (alu_res == '0);
            ov_q <= 1'b1;
         end else if (shifting) begin
            // Intermediate values show on OUT_DATA; flags land with the last step.
            acc <= step[WIDTH-1:0];
            if (shift_done) begin
               c_q  <= step[WIDTH];
               z_q  <= (step[WIDTH-1:0] == '0);
               ov_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_acc.sv
module tb_alu_acc;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         IN_VALID;
   logic         IN_READY;
   logic [3:0]   INST;
   logic [W-1:0] IN_DATA;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [W-1:0] OUT_DATA;
   logic         C;
   logic         Z;
   logic         BUSY;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state
   logic [W-1:0] m_acc;
   logic         m_c;
   logic         m_z;

   alu_acc #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .INST      (INST),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .C         (C),
      .Z         (Z),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Behavioural model: applies one instruction with plain integer arithmetic,
   // returns the number of extra cycles before the result appears.
   task automatic model(input logic [3:0] op, input logic [W-1:0] d, output int lat);
      int a, dd, r, s, n;
      a   = int'(m_acc);
      dd  = int'(d);
      n   = int'(d[2:0]);
      r   = a;
      lat = 0;
      case (op)
         4'h1: begin r = dd; m_c = 1'b0; end
         4'h4, 4'h5: begin
            s = a + dd + ((op == 4'h5) ? int'(m_c) : 0);
            m_c = (s >= 256); r = s % 256;
         end
         4'h6, 4'h7, 4'hB: begin
            s = a - dd - ((op == 4'h7) ? int'(m_c) : 0);
            m_c = (s < 0); r = (s + 256) % 256;
         end
         4'h8: begin r = 255 - a; m_c = 1'b0; end
         4'h9: begin r = (256 - a) % 256; m_c = (a != 0); end
         4'hA: begin r = int'(m_acc | d); m_c = 1'b0; end
         4'hC: begin r = int'(m_acc & d); m_c = 1'b0; end
         4'hE: begin r = int'(m_acc ^ d); m_c = 1'b0; end
         4'hD: begin r = int'(m_acc & d); m_c = 1'b0; end
`ifdef ALU_ACC_SHIFT_EN
         4'h2, 4'h3, 4'hF: begin
            lat = n;
            if (n == 0) m_c = 1'b0;
            else if (op == 4'h2) begin m_c = ((a >> (8 - n)) & 1) != 0; r = (a << n) % 256; end
            else if (op == 4'h3) begin m_c = ((a >> (n - 1)) & 1) != 0; r = a >> n; end
            else begin r = ((a << n) | (a >> (8 - n))) % 256; m_c = (r & 1) != 0; end
         end
`endif
         default: r = a;
      endcase
      m_z = (r == 0);
      if (op != 4'hB && op != 4'hD) m_acc = r[W-1:0];
   endtask

   // Called at a negative edge; returns at the negative edge where the result is checked.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] d);
      int lat;
      chk("in_ready_pre", IN_READY, 1);
      IN_VALID = 1'b1; INST = op; IN_DATA = d;
      model(op, d, lat);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      for (int k = 0; k < lat; k++) begin
         @(negedge CLK);
         chk("busy_mid", BUSY, 1);
         chk("in_ready_mid", IN_READY, 0);
         chk("ov_mid", OUT_VALID, 0);
         @(posedge CLK);
      end
      @(negedge CLK);
      chk("ov_done", OUT_VALID, 1);
      chk("data", OUT_DATA, m_acc);
      chk("c", C, m_c);
      chk("z", Z, m_z);
      chk("busy_done", BUSY, 0);
   endtask

   initial begin
      RST_N = 1'b0; IN_VALID = 1'b0; INST = 4'h0; IN_DATA = '0; OUT_READY = 1'b1;
      m_acc = '0; m_c = 1'b0; m_z = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ov", OUT_VALID, 0);
      chk("rst_data", OUT_DATA, 0);
      chk("rst_c", C, 0);
      chk("rst_z", Z, 0);
      chk("rst_busy", BUSY, 0);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rst_in_ready", IN_READY, 1);

      // Carry-chained arithmetic, back to back
      issue(4'h1, 8'hF0);
      issue(4'h4, 8'h20);
      chk("add_val", OUT_DATA, 8'h10);
      chk("add_c", C, 1);
      issue(4'h5, 8'h00);
      chk("adc_val", OUT_DATA, 8'h11);
      chk("adc_c", C, 0);

      // Borrow, compare, test
      issue(4'h1, 8'h05);
      issue(4'h6, 8'h07);
      chk("sub_val", OUT_DATA, 8'hFE);
      chk("sub_c", C, 1);
      issue(4'hB, 8'hFE);
      chk("cmp_val", OUT_DATA, 8'hFE);
      chk("cmp_z", Z, 1);
      chk("cmp_c", C, 0);
      issue(4'hD, 8'h01);
      chk("tst_z", Z, 1);

      // Shift and rotate
      issue(4'h1, 8'h81);
      issue(4'h2, 8'h03);
`ifdef ALU_ACC_SHIFT_EN
      chk("shl_val", OUT_DATA, 8'h08);
      chk("shl_c", C, 0);
`else
      chk("shl_nop_val", OUT_DATA, 8'h81);
`endif
      issue(4'h1, 8'h81);
      issue(4'hF, 8'h01);
`ifdef ALU_ACC_SHIFT_EN
      chk("rol_val", OUT_DATA, 8'h03);
      chk("rol_c", C, 1);
`endif
      issue(4'h3, 8'h00);

      // Backpressure: result held, input stalled, then pop and accept on one edge
      issue(4'h1, 8'h5A);
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; INST = 4'h4; IN_DATA = 8'h01;
      for (int k = 0; k < 5; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk("bp_ov", OUT_VALID, 1);
         chk("bp_data", OUT_DATA, 8'h5A);
         chk("bp_c", C, m_c);
         chk("bp_z", Z, m_z);
         chk("bp_in_ready", IN_READY, 0);
      end
      OUT_READY = 1'b1;
      #1;
      chk("bp_release_ready", IN_READY, 1);
      begin
         int lat;
         model(4'h4, 8'h01, lat);
      end
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      chk("bp_next_ov", OUT_VALID, 1);
      chk("bp_next_data", OUT_DATA, 8'h5B);

      // Randomized instruction stream against the model
      for (int i = 0; i < 60; i++) begin
         logic [3:0] op;
         logic [W-1:0] d;
         op = 4'($urandom_range(0, 15));
         d  = W'($urandom);
         issue(op, d);
      end

      // Reset during the third cycle of a 7-bit shift
      issue(4'h1, 8'hA5);
      IN_VALID = 1'b1; INST = 4'h2; IN_DATA = 8'h07;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
`ifdef ALU_ACC_SHIFT_EN
      chk("abort_busy_before", BUSY, 1);
`endif
      RST_N = 1'b0;
      #1;
      chk("abort_ov", OUT_VALID, 0);
      chk("abort_data", OUT_DATA, 0);
      chk("abort_c", C, 0);
      chk("abort_z", Z, 0);
      chk("abort_busy", BUSY, 0);
      m_acc = '0; m_c = 1'b0; m_z = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         chk("abort_no_ov", OUT_VALID, 0);
         chk("abort_idle", IN_READY, 1);
      end
      issue(4'h4, 8'h07);
      chk("post_abort_add", OUT_DATA, 8'h07);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
